// File: rtl/uart_pkg.sv
// Shared types and defaults for the FIFO-fed UART transmitter.
// The PARITY state exists only when FIFO_UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int DEF_DATA_W       = 8;

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, START, DATA, PARITY, STOP} tx_state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, WAIT, START, DATA, STOP} tx_state_t;
`endif

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Bundle of the transmitter's FIFO handshake and serial-side signals.
// master = transmitter side, slave = FIFO/host side.
interface fifo_uart_tx_if #(
  parameter int DATA_W = 8
) ();

  logic              tx_en;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_ready_pulse;
  logic              tx;
  logic              busy;
  logic              done_pulse;

  modport master (
    input  tx_en, fifo_empty, fifo_rd_data, fifo_ready_pulse,
    output fifo_rd_en, tx, busy, done_pulse
  );

  modport slave (
    output tx_en, fifo_empty, fifo_rd_data, fifo_ready_pulse,
    input  fifo_rd_en, tx, busy, done_pulse
  );

endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period timer: counts CLKS_PER_BIT clocks and pulses bit_end on the last one.
// clear holds the count at zero so the first bit after it is a full period.
module baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);

  localparam int               CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || bit_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bit_end = !clear && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls one word per frame from a FIFO with a registered empty flag.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_W       = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_tx_en,
  input  logic              i_fifo_empty,
  output logic              o_fifo_rd_en,
  input  logic [DATA_W-1:0] i_fifo_rd_data,
  input  logic              i_fifo_ready_pulse,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_done_pulse
);

  localparam int               BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              wait_q, wait_d;
  logic              tx_q, tx_d;
  logic              bit_end, baud_clear;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  // Baud counter idles at zero outside the serial states, so START gets a full bit.
  assign baud_clear = (state_q == IDLE) || (state_q == REQ) || (state_q == WAIT);

  baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (baud_clear),
    .bit_end (bit_end)
  );

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    wait_d    = wait_q;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE:  if (i_tx_en && !i_fifo_empty) state_d = REQ;
      REQ: begin
        wait_d  = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        if (i_fifo_ready_pulse) begin
          shift_d = i_fifo_rd_data;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_d = ^i_fifo_rd_data;
`endif
          state_d = START;
        end else if (wait_q) begin
          state_d = IDLE;  // empty flag was stale: nothing came back
        end else begin
          wait_d = 1'b1;
        end
      end
      START: begin
        bit_cnt_d = '0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP:    if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Line level is decoded from the next state so the output flop tracks state with no lag.
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      wait_q    <= 1'b0;
      tx_q      <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      wait_q    <= wait_d;
      tx_q      <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign o_tx         = tx_q;
  assign o_fifo_rd_en = (state_q == REQ);
  assign o_busy       = (state_q != IDLE);
  assign o_done_pulse = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a FIFO model with a lagging empty flag feeds the DUT,
// and a monitor compares every serial cycle against frames queued when words are pushed.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FRAME_BITS = DW + 3;
`else
  localparam int FRAME_BITS = DW + 2;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fifo_uart_tx_if #(.DATA_W(DW)) bus ();

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_tx_en            (bus.tx_en),
    .i_fifo_empty       (bus.fifo_empty),
    .o_fifo_rd_en       (bus.fifo_rd_en),
    .i_fifo_rd_data     (bus.fifo_rd_data),
    .i_fifo_ready_pulse (bus.fifo_ready_pulse),
    .o_tx               (bus.tx),
    .o_busy             (bus.busy),
    .o_done_pulse       (bus.done_pulse)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int rd_cnt      = 0;
  int done_cnt    = 0;
  int start_log[$];
  int done_log[$];
  logic [DW-1:0] fq[$];
  logic exp_q[$];
  bit mon_hold   = 1'b0;
  bit mon_active = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Queue a word in the FIFO model and, if it should be sent, its expected line levels.
  task automatic push_byte(input logic [DW-1:0] b, input bit expect_frame);
    fq.push_back(b);
    if (expect_frame) begin
      exp_q.push_back(1'b0);
      for (int i = 0; i < DW; i++) exp_q.push_back(b[i]);
`ifdef FIFO_UART_TX_PARITY_EN
      exp_q.push_back(^b);
`endif
      exp_q.push_back(1'b1);
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while ((bus.busy !== 1'b0 || mon_active || exp_q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < max_cyc), 1);
  endtask

  always @(posedge clk) cyc++;

  // FIFO model: empty flag reflects the occupancy before this edge's pop, so it lags a cycle.
  always @(posedge clk) begin
    bus.fifo_empty       <= (fq.size() == 0);
    bus.fifo_ready_pulse <= 1'b0;
    if (bus.fifo_rd_en === 1'b1 && fq.size() != 0) begin
      bus.fifo_rd_data     <= fq.pop_front();
      bus.fifo_ready_pulse <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (bus.fifo_rd_en === 1'b1) rd_cnt++;
    if (bus.done_pulse === 1'b1) begin
      done_cnt++;
      done_log.push_back(cyc);
    end
  end

  initial begin : monitor
    logic exp_bit;
    forever begin
      @(negedge clk);
      if (!mon_hold && rst_n && bus.tx === 1'b0) begin
        mon_active = 1'b1;
        start_log.push_back(cyc);
        check("frame_expected", 32'(exp_q.size() >= FRAME_BITS), 1);
        for (int b = 0; b < FRAME_BITS; b++) begin
          exp_bit = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b1;
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            check("tx_bit", bus.tx, exp_bit);
            check("done_pulse", bus.done_pulse, 32'(b == FRAME_BITS - 1 && c == CPB - 1));
          end
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int rd0, d0, s0, n;
    bus.tx_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", bus.tx, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_rd_en", bus.fifo_rd_en, 0);
    check("rst_done", bus.done_pulse, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_tx", bus.tx, 1);

    // Single frame 0xA5
    rd0 = rd_cnt; d0 = done_cnt;
    push_byte(8'hA5, 1'b1);
    bus.tx_en = 1'b1;
    wait_idle(200);
    check("a5_rd_en", rd_cnt - rd0, 1);
    check("a5_done", done_cnt - d0, 1);
    check("a5_len", done_log[$] - start_log[$] + 1, FRAME_BITS * CPB);

    // Back-to-back 0x00, 0xFF
    rd0 = rd_cnt; d0 = done_cnt; s0 = start_log.size();
    push_byte(8'h00, 1'b1);
    push_byte(8'hFF, 1'b1);
    wait_idle(300);
    check("b2b_rd_en", rd_cnt - rd0, 2);
    check("b2b_done", done_cnt - d0, 2);
    check("b2b_starts", start_log.size() - s0, 2);
    check("b2b_gap", start_log[$] - done_log[done_log.size() - 2], 4);

    // Stale empty flag: entry removed behind the DUT's back
    bus.tx_en = 1'b0;
    push_byte(8'h11, 1'b0);
    repeat (3) @(negedge clk);
    rd0 = rd_cnt; d0 = done_cnt;
    void'(fq.pop_front());
    bus.tx_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stale_busy", bus.busy, 32'(i < 3));
      check("stale_tx", bus.tx, 1);
      check("stale_done", bus.done_pulse, 0);
    end
    check("stale_rd_en", rd_cnt - rd0, 1);
    check("stale_no_done", done_cnt - d0, 0);

    // tx_en gating, then drop tx_en mid-frame
    bus.tx_en = 1'b0;
    rd0 = rd_cnt; d0 = done_cnt;
    push_byte(8'h55, 1'b1);
    repeat (20) @(negedge clk);
    check("gate_rd_en", rd_cnt - rd0, 0);
    check("gate_busy", bus.busy, 0);
    bus.tx_en = 1'b1;
    n = 0;
    while (bus.busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("gate_start", 32'(n < 20), 1);
    push_byte(8'h66, 1'b0);
    repeat (8) @(negedge clk);
    bus.tx_en = 1'b0;
    wait_idle(200);
    repeat (20) @(negedge clk);
    check("drop_rd_en", rd_cnt - rd0, 1);
    check("drop_done", done_cnt - d0, 1);
    check("drop_busy", bus.busy, 0);
    fq.delete();
    repeat (2) @(negedge clk);

    // Asynchronous reset during DATA bit 3 of 0x3C
    mon_hold = 1'b1;
    d0 = done_cnt;
    push_byte(8'h3C, 1'b0);
    bus.tx_en = 1'b1;
    n = 0;
    while (bus.tx !== 1'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("rst_frame_start", 32'(n < 30), 1);
    repeat (5) @(negedge clk);
    check("rst_bit0_tx", bus.tx, 0);
    repeat (12) @(negedge clk);
    check("rst_bit3_tx", bus.tx, 1);
    check("rst_bit3_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_tx", bus.tx, 1);
    check("async_busy", bus.busy, 0);
    check("async_rd_en", bus.fifo_rd_en, 0);
    check("async_done", bus.done_pulse, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd0 = rd_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_tx", bus.tx, 1);
      check("post_rst_busy", bus.busy, 0);
    end
    check("post_rst_rd_en", rd_cnt - rd0, 0);
    check("post_rst_done", done_cnt - d0, 0);
    mon_hold = 1'b0;

`ifdef FIFO_UART_TX_PARITY_EN
    // Parity frames: 0x07 carries parity 1, 0xA5 carries parity 0
    d0 = done_cnt;
    push_byte(8'h07, 1'b1);
    wait_idle(200);
    check("par07_len", done_log[$] - start_log[$] + 1, 44);
    push_byte(8'hA5, 1'b1);
    wait_idle(200);
    check("parA5_len", done_log[$] - start_log[$] + 1, 44);
    check("par_done", done_cnt - d0, 2);
`endif

    bus.tx_en = 1'b0;
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter DATA_W, default 8, meaning data bits per frame and FIFO read-data width.
REQ-003 SHALL have port clk, input, 1, system clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port i_tx_en, input, 1, permits new frames to start.
REQ-006 SHALL have port i_fifo_empty, input, 1, registered FIFO empty flag; may lag the true FIFO state by one cycle.
REQ-007 SHALL have port o_fifo_rd_en, output, 1, FIFO read request.
REQ-008 SHALL have port i_fifo_rd_data, input, DATA_W, FIFO read data, valid when i_fifo_ready_pulse=1.
REQ-009 SHALL have port i_fifo_ready_pulse, input, 1, one-cycle strobe that read data is valid; arrives the cycle after an accepted o_fifo_rd_en.
REQ-010 SHALL have port o_tx, output, 1, serial line, idle high.
REQ-011 SHALL have port o_busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port o_done_pulse, output, 1, one-cycle strobe at frame completion.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, WAIT, START, DATA, PARITY, STOP.
REQ-014 IDLE -> REQ when i_tx_en=1 and i_fifo_empty=0; otherwise remain in IDLE.
REQ-015 REQ SHALL last exactly one cycle with o_fifo_rd_en=1, then go to WAIT; o_fifo_rd_en SHALL be 0 in every other state.
REQ-016 WAIT: on i_fifo_ready_pulse=1, capture i_fifo_rd_data into the shift register and go to START; if no pulse within 2 WAIT cycles (stale empty flag), return to IDLE with no frame and no o_done_pulse.
REQ-017 START drives o_tx=0; DATA drives DATA_W bits LSB first; STOP drives o_tx=1; each bit is held exactly CLKS_PER_BIT cycles.
REQ-018 The bit counter SHALL wrap from DATA_W-1 to exit DATA; the baud counter SHALL reload to 0 at every bit boundary.
REQ-019 o_done_pulse SHALL assert for one cycle on the last STOP cycle; next state is IDLE.
REQ-020 Back-to-back frames: the next start bit SHALL begin exactly 3 cycles after the STOP bit ends (IDLE, REQ, WAIT).
REQ-021 i_tx_en deassertion mid-frame SHALL NOT abort the frame; it only blocks the IDLE->REQ transition.
REQ-022 i_fifo_ready_pulse outside WAIT SHALL be ignored.
REQ-023 o_tx SHALL be driven from a flop (glitch-free).

Reset
REQ-024 Asynchronous assertion of rst_n SHALL force state=IDLE, o_tx=1, o_fifo_rd_en=0, o_busy=0, o_done_pulse=0, and baud/bit counters and shift register to 0, including mid-frame.
REQ-025 After deassertion, the first frame start SHALL require a fresh IDLE->REQ evaluation.

Configuration
REQ-026 With FIFO_UART_TX_PARITY_EN defined, a PARITY state between DATA and STOP SHALL drive the even parity bit (XOR of data bits) for CLKS_PER_BIT cycles; frame length = (DATA_W+3)*CLKS_PER_BIT.
REQ-027 Without FIFO_UART_TX_PARITY_EN, PARITY SHALL be unreachable and omitted; DATA goes directly to STOP; frame length = (DATA_W+2)*CLKS_PER_BIT.

Structure
REQ-028 Package uart_pkg SHALL hold the tx state enum typedef and default CLKS_PER_BIT/DATA_W constants.
REQ-029 Sub-module baud_gen SHALL contain the CLKS_PER_BIT counter (inputs clk, rst_n, clear; output bit_end pulse).

Verification (CLKS_PER_BIT=4, DATA_W=8, bench FIFO model with registered empty)
REQ-030 Push 0xA5, i_tx_en=1 -> one o_fifo_rd_en cycle; o_tx per 4 cycles: 0,1,0,1,0,0,1,0,1,1; one o_done_pulse; 40-cycle frame.
REQ-031 Push 0x00,0xFF back-to-back -> two frames, start bit of second begins 3 cycles after first STOP ends; exactly two o_done_pulse.
REQ-032 Pop last entry while i_fifo_empty still 0 -> extra REQ, no ready pulse, return to IDLE after 2 WAIT cycles, o_tx stays 1, no o_done_pulse.
REQ-033 Assert rst_n=0 during DATA bit 3 of 0x3C -> o_tx=1 and o_busy=0 immediately; after release with FIFO empty, o_tx stays 1.
REQ-034 i_tx_en=0 with 0x55 queued -> no o_fifo_rd_en; drop i_tx_en mid-frame -> frame completes, no next REQ.
REQ-035 FIFO_UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1, 44-cycle frame; send 0xA5 -> parity bit 0.
